// File: rtl/sha256_w_stream_reader.sv
// SHA-256 message schedule reader: takes one 512-bit block and streams W_0..W_(ROUNDS-1) over a valid/ready port.
// Build macro SHA256_DOUBLE_PAD_EN: load only a 256-bit digest and apply the fixed second-hash padding.
module sha256_w_stream_reader #(
    parameter int ROUNDS = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_in,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [5:0]   w_idx,
    output logic         w_last,
    output logic         busy
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] win [16];
    logic [5:0]  idx;
    logic [31:0] w_new;
    logic        blk_take;
    logic        w_take;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Word i of the block as it enters the window (big-endian word order).
    function automatic logic [31:0] load_word(input logic [511:0] blk, input int i);
`ifdef SHA256_DOUBLE_PAD_EN
        if (i < 8) begin
            return blk[511 - 32*i -: 32];
        end else if (i == 8) begin
            return 32'h8000_0000;
        end else if (i == 15) begin
            return 32'h0000_0100;
        end else begin
            return 32'h0000_0000;
        end
`else
        return blk[511 - 32*i -: 32];
`endif
    endfunction

    assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_comb begin
        state_next = state;
        blk_ready  = 1'b0;
        w_valid    = 1'b0;
        w_out      = 32'h0;
        w_idx      = 6'd0;
        w_last     = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                blk_ready = !RST;
                if (blk_valid) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                busy    = 1'b1;
                w_valid = !RST;
                w_out   = win[0];
                w_idx   = idx;
                w_last  = !RST && (idx == LAST_IDX);
                if (w_ready && (idx == LAST_IDX)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign blk_take = blk_ready & blk_valid;
    assign w_take   = w_valid & w_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sliding window: W_t always sits in win[0]; each handshake shifts in W_(t+16).
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'h0;
            end
        end else if (blk_take) begin
            idx <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= load_word(blk_in, i);
            end
        end else if (w_take) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i + 1];
            end
            win[15] <= w_new;
            idx     <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
        end
    end

endmodule
